// File: rtl/neopixel_multi_driver.sv
// neopixel_multi_driver: Avalon-MM controlled multi-channel WS281x/SK6812 serializer
// with per-channel pixel RAM and one shared bit timer driving all lines in lockstep.
module neopixel_multi_driver #(
  parameter int NUM_CHANNELS = 4,
  parameter int MAX_PIXELS = 64,
  parameter int RGBW = 0,
  parameter int T0H = 20,
  parameter int T1H = 40,
  parameter int TBIT = 63,
  parameter int TLATCH = 3000,
  parameter int ADDR_W = $clog2(NUM_CHANNELS * MAX_PIXELS) + 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_W-1:0]       avs_address,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  input  logic                    avs_read,
  output logic [31:0]             avs_readdata,
  output logic [NUM_CHANNELS-1:0] neopixel_one_wire
);
  localparam int BPP = RGBW != 0 ? 32 : 24;
  localparam int PIX_W = $clog2(MAX_PIXELS);
  localparam int CH_W = $clog2(NUM_CHANNELS);
  localparam int TMR_W = $clog2(TLATCH > TBIT ? TLATCH : TBIT) + 1;
  localparam int BIT_W = $clog2(BPP);
  localparam logic [TMR_W-1:0] T0 = TMR_W'(T0H);
  localparam logic [TMR_W-1:0] T1 = TMR_W'(T1H);
  localparam logic [TMR_W-1:0] TB1 = TMR_W'(TBIT - 1);
  localparam logic [TMR_W-1:0] TB2 = TMR_W'(TBIT - 2);
  localparam logic [TMR_W-1:0] TL1 = TMR_W'(TLATCH - 1);
  localparam logic [TMR_W-1:0] TL2 = TMR_W'(TLATCH - 2);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BPP - 1);
  localparam logic [15:0] MAXP = 16'(MAX_PIXELS);
  localparam logic [31:0] PARAMS = {RGBW != 0, 7'd0, 8'(NUM_CHANNELS), 16'(MAX_PIXELS)};

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, LATCH} state_t;

  state_t state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [15:0] total_q, total_d, npix_q, npix_d;
  logic [31:0] frame_q, frame_d, rdata_q, rdata_d;
  logic cont_q, cont_d;
  logic [BPP-1:0] sh_q [NUM_CHANNELS];
  logic [BPP-1:0] sh_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] line_q, line_d;
  logic [31:0] mem [NUM_CHANNELS][MAX_PIXELS];
  logic sel_pix, a_hi, wr_reg, start, busy, more, last_bit;
  logic [CH_W-1:0] a_ch;
  logic [PIX_W-1:0] a_pix;
  logic [15:0] nxt;
  logic [31:0] reg_rd;

  // Stored word is 0xWWRRGGBB; wire order is G,R,B[,W] MSB first.
  function automatic logic [BPP-1:0] grbw(input logic [31:0] w);
    return BPP'({w[15:8], w[23:16], w[7:0], w[31:24]} >> (32 - BPP));
  endfunction

  assign sel_pix = avs_address[ADDR_W-1];
  assign a_ch = avs_address[PIX_W +: CH_W];
  assign a_pix = avs_address[PIX_W-1:0];
  assign a_hi = |avs_address[ADDR_W-2:2];
  assign wr_reg = avs_write && !sel_pix;
  assign start = wr_reg && !a_hi && avs_address[1:0] == 2'd0 && avs_writedata[0];
  assign busy = state_q != IDLE;
  assign nxt = 16'(pix_q) + 16'd1;
  assign more = nxt < total_q;
  assign last_bit = bit_q == LAST_BIT;
  assign reg_rd = a_hi ? 32'd0 :
                  avs_address[1:0] == 2'd0 ? {29'd0, cont_q, busy, 1'b0} :
                  avs_address[1:0] == 2'd1 ? {16'd0, npix_q} :
                  avs_address[1:0] == 2'd2 ? frame_q : PARAMS;
  assign avs_readdata = rdata_q;
  assign neopixel_one_wire = line_q;

  always_ff @(posedge clk)
    if (avs_write && sel_pix) mem[a_ch][a_pix] <= avs_writedata;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      tmr_q <= '0;
      bit_q <= '0;
      pix_q <= '0;
      total_q <= '0;
      npix_q <= '0;
      frame_q <= '0;
      cont_q <= 1'b0;
      rdata_q <= '0;
      line_q <= '0;
      sh_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      tmr_q <= tmr_d;
      bit_q <= bit_d;
      pix_q <= pix_d;
      total_q <= total_d;
      npix_q <= npix_d;
      frame_q <= frame_d;
      cont_q <= cont_d;
      rdata_q <= rdata_d;
      line_q <= line_d;
      sh_q <= sh_d;
    end

  always_comb begin
    state_d = state_q;
    tmr_d = tmr_q;
    bit_d = bit_q;
    pix_d = pix_q;
    total_d = total_q;
    frame_d = frame_q;
    sh_d = sh_q;
    line_d = '0;
    rdata_d = avs_read ? (sel_pix ? mem[a_ch][a_pix] : reg_rd) : rdata_q;
    cont_d = wr_reg && !a_hi && avs_address[1:0] == 2'd0 ? avs_writedata[2] : cont_q;
    npix_d = wr_reg && !a_hi && avs_address[1:0] == 2'd1 ?
             (avs_writedata[15:0] > MAXP ? MAXP : avs_writedata[15:0]) : npix_q;
    case (state_q)
      IDLE:
        if (start && npix_q != 16'd0) begin
          state_d = FETCH;
          total_d = npix_q;
          pix_d = '0;
        end
      // Occupies the last low cycle of the previous bit, so pixels abut seamlessly.
      FETCH: begin
        for (int c = 0; c < NUM_CHANNELS; c++) sh_d[c] = grbw(mem[c][pix_q]);
        bit_d = '0;
        tmr_d = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        for (int c = 0; c < NUM_CHANNELS; c++) line_d[c] = tmr_q < (sh_q[c][BPP-1] ? T1 : T0);
        tmr_d = tmr_q == TB1 ? '0 : tmr_q + TMR_W'(1);
        if (tmr_q == TB1) begin
          for (int c = 0; c < NUM_CHANNELS; c++) sh_d[c] = sh_q[c] << 1;
          bit_d = bit_q + BIT_W'(1);
        end
        if (last_bit && more && tmr_q == TB2) begin
          state_d = FETCH;
          pix_d = pix_q + PIX_W'(1);
        end else if (last_bit && !more && tmr_q == TB1) begin
          state_d = LATCH;
          tmr_d = '0;
        end
      end
      LATCH: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (tmr_q == TL2 && cont_q && npix_q != 16'd0) begin
          state_d = FETCH;
          frame_d = frame_q + 32'd1;
          total_d = npix_q;
          pix_d = '0;
        end else if (tmr_q == TL1) begin
          state_d = IDLE;
          frame_d = frame_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_neopixel_multi_driver.sv
// tb_neopixel_multi_driver: directed stimulus with scoreboards for Avalon reads
// and for per-channel decoded bit pulses on the one-wire lines.
module tb_neopixel_multi_driver;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [8:0] avs_address = '0;
  logic avs_write = 1'b0;
  logic avs_read = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic [3:0] neopixel_one_wire;
  int compared = 0;
  int mismatched = 0;
  int exp_q [4][$];
  logic [31:0] rq [$];
  string rn [$];
  logic [23:0] grb_m [4][64];
  int fc = 0;
  bit mon_en = 1'b0;
  logic rv = 1'b0;
  int hi [4];
  int since [4];
  logic [3:0] prev = '0;
  logic [31:0] pat_w [4] = '{32'h000001, 32'h800000, 32'h00AA55, 32'h00FFFF};
  logic [23:0] pat_g [4] = '{24'h000001, 24'h008000, 24'hAA0055, 24'hFF00FF};

  neopixel_multi_driver dut (
    .clk(clk),
    .reset_n(reset_n),
    .avs_address(avs_address),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_read(avs_read),
    .avs_readdata(avs_readdata),
    .neopixel_one_wire(neopixel_one_wire)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rv <= avs_read;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [8:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address = a;
    avs_writedata = d;
    avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [8:0] a, input logic [31:0] e, input string n);
    @(negedge clk);
    avs_address = a;
    avs_read = 1'b1;
    rq.push_back(e);
    rn.push_back(n);
    @(negedge clk);
    avs_read = 1'b0;
  endtask

  task automatic wpix(input int c, input int p, input logic [31:0] w, input logic [23:0] g);
    wr({1'b1, 2'(c), 6'(p)}, w);
    grb_m[c][p] = g;
  endtask

  task automatic push_pix(input int p);
    for (int c = 0; c < 4; c++)
      for (int b = 23; b >= 0; b--) exp_q[c].push_back(grb_m[c][p][b] ? 40 : 20);
  endtask

  initial begin : mon_read
    logic [31:0] e;
    string n;
    forever begin
      @(negedge clk);
      if (rv) begin
        compared++;
        if (rq.size() == 0) begin
          mismatched++;
          $display("FAIL read_unexpected: got %h want no read", avs_readdata);
        end else begin
          e = rq.pop_front();
          n = rn.pop_front();
          if (avs_readdata !== e) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", n, avs_readdata, e);
          end
        end
      end
    end
  end

  initial begin : mon_line
    int e;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        if (!mon_en) begin
          since[c] = 1000;
          hi[c] = 0;
        end else if (neopixel_one_wire[c] && !prev[c]) begin
          if (since[c] < 200) begin
            compared++;
            if (since[c] != 63) begin
              mismatched++;
              $display("FAIL period_ch%0d: got %0d cycles want 63", c, since[c]);
            end
          end
          since[c] = 0;
          hi[c] = 1;
        end else if (neopixel_one_wire[c]) begin
          hi[c]++;
        end else if (prev[c]) begin
          compared++;
          if (exp_q[c].size() == 0) begin
            mismatched++;
            $display("FAIL pulse_ch%0d: got unexpected %0d-cycle pulse want none", c, hi[c]);
          end else begin
            e = exp_q[c].pop_front();
            if (hi[c] != e) begin
              mismatched++;
              $display("FAIL pulse_ch%0d: got %0d high cycles want %0d", c, hi[c], e);
            end
          end
        end
        if (since[c] < 1000) since[c]++;
        prev[c] = neopixel_one_wire[c];
      end
    end
  end

  initial begin
    cyc(3);
    reset_n = 1'b1;
    rd(9'd3, 32'h00040040, "params");
    rd(9'd0, 32'd0, "ctrl_rst");
    rd(9'd1, 32'd0, "npix_rst");
    rd(9'd2, 32'd0, "frame_rst");
    // Start a frame, then pull reset while a line is high.
    wr(9'd1, 32'd1);
    wr(9'd0, 32'd1);
    for (int i = 0; i < 300 && neopixel_one_wire == 4'd0; i++) @(negedge clk);
    compared++;
    if (neopixel_one_wire == 4'd0) begin
      mismatched++;
      $display("FAIL line_active: got %b want nonzero", neopixel_one_wire);
    end
    #7 reset_n = 1'b0;
    #1;
    compared++;
    if (neopixel_one_wire !== 4'd0) begin
      mismatched++;
      $display("FAIL async_reset: got %b want 0000", neopixel_one_wire);
    end
    cyc(3);
    reset_n = 1'b1;
    mon_en = 1'b1;
    rd(9'd0, 32'd0, "ctrl_rst2");
    rd(9'd1, 32'd0, "npix_rst2");
    rd(9'd2, 32'd0, "frame_rst2");
    // Single pixel: ch0 G=00 R=FF B=00.
    wpix(0, 0, 32'h00FF0000, 24'h00FF00);
    for (int c = 1; c < 4; c++) wpix(c, 0, pat_w[c], pat_g[c]);
    wr(9'd1, 32'd1);
    push_pix(0);
    wr(9'd0, 32'd1);
    cyc(1000);
    rd(9'd0, 32'd2, "ctrl_busy");
    cyc(3600);
    rd(9'd0, 32'd0, "ctrl_done1");
    fc = 1;
    rd(9'd2, 32'(fc), "frame_1");
    // Four channels, three pixels of distinct patterns.
    for (int c = 0; c < 4; c++)
      for (int p = 0; p < 3; p++) wpix(c, p, pat_w[(c + p) % 4], pat_g[(c + p) % 4]);
    wr(9'd1, 32'd3);
    for (int p = 0; p < 3; p++) push_pix(p);
    wr(9'd0, 32'd1);
    cyc(7700);
    rd(9'd0, 32'd0, "ctrl_done3");
    fc = 2;
    rd(9'd2, 32'(fc), "frame_3pix");
    // Zero pixels: START ignored; oversize NUM_PIXELS clamps.
    wr(9'd1, 32'd0);
    wr(9'd0, 32'd1);
    rd(9'd0, 32'd0, "ctrl_zero");
    cyc(300);
    rd(9'd1, 32'd0, "npix_zero");
    wr(9'd1, 32'd200);
    rd(9'd1, 32'd64, "npix_clamp");
    rd(9'd2, 32'(fc), "frame_zero");
    // Continuous refresh of two pixels, cleared mid-frame three.
    wr(9'd1, 32'd2);
    for (int f = 0; f < 3; f++) begin
      push_pix(0);
      push_pix(1);
    end
    wr(9'd0, 32'd5);
    cyc(100);
    rd(9'd0, 32'd6, "ctrl_cont");
    cyc(8900);
    rd(9'd2, 32'(fc + 1), "frame_cont1");
    cyc(6000);
    rd(9'd2, 32'(fc + 2), "frame_cont2");
    wr(9'd0, 32'd0);
    cyc(4000);
    rd(9'd2, 32'(fc + 3), "frame_cont3");
    rd(9'd0, 32'd0, "ctrl_cont_off");
    cyc(6100);
    rd(9'd2, 32'(fc + 3), "frame_cont_stop");
    fc = fc + 3;
    // Rewrite pixel 1 while pixel 0 shifts; a second START is ignored.
    push_pix(0);
    wr(9'd0, 32'd1);
    cyc(300);
    for (int c = 0; c < 4; c++) wpix(c, 1, pat_w[(c + 3) % 4], pat_g[(c + 3) % 4]);
    push_pix(1);
    wr(9'd0, 32'd1);
    cyc(6100);
    rd(9'd2, 32'(fc + 1), "frame_busy_wr");
    rd(9'd0, 32'd0, "ctrl_busy_wr");
    cyc(20);
    for (int c = 0; c < 4; c++) begin
      compared++;
      if (exp_q[c].size() != 0) begin
        mismatched++;
        $display("FAIL leftover_ch%0d: got %0d pending bits want 0", c, exp_q[c].size());
      end
    end
    compared++;
    if (rq.size() != 0) begin
      mismatched++;
      $display("FAIL leftover_reads: got %0d pending want 0", rq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
